// File: rtl/lpc_synth_dec.sv
// LPC decoder/synthesiser: impulse-train or LFSR-noise excitation driven through
// a 10th-order all-pole synthesis filter evaluated by one sequential MAC.
module lpc_synth_dec #(
    parameter int                       DATA_W      = 16,
    parameter int                       COEF_W      = 16,
    parameter int                       COEF_FRAC   = 13,
    parameter logic signed [DATA_W-1:0] PULSE_AMP   = 16'sd4096,
    parameter int                       NOISE_SHIFT = 3,
    parameter logic [15:0]              LFSR_SEED   = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [COEF_W-1:0] A0,
    input  logic signed [COEF_W-1:0] A1,
    input  logic signed [COEF_W-1:0] A2,
    input  logic signed [COEF_W-1:0] A3,
    input  logic signed [COEF_W-1:0] A4,
    input  logic signed [COEF_W-1:0] A5,
    input  logic signed [COEF_W-1:0] A6,
    input  logic signed [COEF_W-1:0] A7,
    input  logic signed [COEF_W-1:0] A8,
    input  logic signed [COEF_W-1:0] A9,
    input  logic signed [COEF_W-1:0] A10,
    input  logic                     voiced,
    input  logic [15:0]              freq_count,
    input  logic                     load,
    input  logic                     start_dec,
    input  logic                     stop_dec,
    input  logic                     v,
    output logic signed [DATA_W-1:0] y,
    output logic                     vout,
    output logic                     running,
    output logic                     overrun
);

    localparam int ACC_W = 40;
    localparam int PROD_W = COEF_W + DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MAC, S_SAT} state_t;

    state_t state, state_nxt;

    logic signed [COEF_W-1:0] coef_in  [0:9];
    logic signed [COEF_W-1:0] coef_sh  [0:9];
    logic signed [COEF_W-1:0] coef_act [0:9];
    logic signed [DATA_W-1:0] hist     [0:9];
    logic                     voiced_sh;
    logic [15:0]              fc_sh;
    logic [15:0]              lfsr;
    logic [15:0]              pitch_cnt;
    logic [15:0]              pitch_nxt;
    logic [3:0]               mac_idx;
    logic signed [DATA_W-1:0] noise_p0;
    logic signed [DATA_W-1:0] exc_p0;
    logic signed [PROD_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [DATA_W-1:0] y_p2;
    logic                     vld_p2;
    logic                     ovr;
    logic                     unused_a0;

    // A0 is the implicit unity term of the predictor and never enters the MAC.
    assign unused_a0 = ^A0;

    assign coef_in[0] = A1;
    assign coef_in[1] = A2;
    assign coef_in[2] = A3;
    assign coef_in[3] = A4;
    assign coef_in[4] = A5;
    assign coef_in[5] = A6;
    assign coef_in[6] = A7;
    assign coef_in[7] = A8;
    assign coef_in[8] = A9;
    assign coef_in[9] = A10;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> COEF_FRAC;
        if (s > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    // Stage p0: excitation selection and MAC product
    assign noise_p0 = DATA_W'($signed(lfsr) >>> NOISE_SHIFT);
    assign prod_p0  = coef_act[mac_idx] * hist[mac_idx];

    always_comb begin
        exc_p0    = noise_p0;
        pitch_nxt = pitch_cnt;
        if (voiced_sh && (fc_sh != 16'd0)) begin
            exc_p0    = (pitch_cnt == 16'd0) ? PULSE_AMP : '0;
            pitch_nxt = (pitch_cnt >= fc_sh - 16'd1) ? 16'd0 : pitch_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop_dec)
            state_nxt = S_IDLE;
        else if (start_dec)
            state_nxt = S_WAIT;
        else begin
            case (state)
                S_WAIT:  if (v) state_nxt = S_MAC;
                S_MAC:   if (mac_idx == 4'd9) state_nxt = S_SAT;
                S_SAT:   state_nxt = S_WAIT;
                default: state_nxt = state;
            endcase
        end
    end

    // Stage p1: accumulator; stage p2: saturated output and history shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                coef_sh[i]  <= '0;
                coef_act[i] <= '0;
                hist[i]     <= '0;
            end
            voiced_sh <= 1'b0;
            fc_sh     <= '0;
            lfsr      <= LFSR_SEED;
            pitch_cnt <= '0;
            mac_idx   <= '0;
            acc_p1    <= '0;
            y_p2      <= '0;
            vld_p2    <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (load) begin
                for (int i = 0; i < 10; i++)
                    coef_sh[i] <= coef_in[i];
                voiced_sh <= voiced;
                fc_sh     <= freq_count;
            end
            if (stop_dec) begin
                for (int i = 0; i < 10; i++)
                    hist[i] <= '0;
            end else if (start_dec) begin
                for (int i = 0; i < 10; i++) begin
                    coef_act[i] <= coef_sh[i];
                    hist[i]     <= '0;
                end
                lfsr      <= LFSR_SEED;
                pitch_cnt <= '0;
                mac_idx   <= '0;
                ovr       <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (v) begin
                            // Coefficients only move into the MAC at sample acceptance.
                            for (int i = 0; i < 10; i++)
                                coef_act[i] <= coef_sh[i];
                            acc_p1    <= ACC_W'(exc_p0) <<< COEF_FRAC;
                            pitch_cnt <= pitch_nxt;
                            lfsr      <= lfsr_next(lfsr);
                            mac_idx   <= '0;
                        end
                    end
                    S_MAC: begin
                        acc_p1  <= acc_p1 - ACC_W'(prod_p0);
                        mac_idx <= (mac_idx == 4'd9) ? 4'd0 : mac_idx + 4'd1;
                        if (v) ovr <= 1'b1;
                    end
                    S_SAT: begin
                        y_p2    <= sat_out(acc_p1);
                        vld_p2  <= 1'b1;
                        hist[0] <= sat_out(acc_p1);
                        for (int i = 1; i < 10; i++)
                            hist[i] <= hist[i-1];
                        if (v) ovr <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign y       = y_p2;
    assign vout    = vld_p2;
    assign running = (state != S_IDLE);
    assign overrun = ovr;

endmodule

// File: tb/tb_lpc_synth_dec.sv
// Bench for lpc_synth_dec: table of frame vectors through a y/latency scoreboard,
// plus hand sequences for overrun, mid-MAC load, async reset and stop handling.
module tb_lpc_synth_dec;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] a [0:10];
    logic               voiced;
    logic [15:0]        freq_count;
    logic               load, start_dec, stop_dec, v;
    logic signed [15:0] y;
    logic               vout, running, overrun;

    always #5 clk = ~clk;

    lpc_synth_dec dut (
        .clk(clk), .rst(rst),
        .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]),
        .A6(a[6]), .A7(a[7]), .A8(a[8]), .A9(a[9]), .A10(a[10]),
        .voiced(voiced), .freq_count(freq_count), .load(load),
        .start_dec(start_dec), .stop_dec(stop_dec), .v(v),
        .y(y), .vout(vout), .running(running), .overrun(overrun)
    );

    typedef struct packed {
        logic [3:0]        k;
        logic [15:0]       aval;
        logic              vcd;
        logic [15:0]       fc;
        logic [3:0]        n;
        logic [11:0][15:0] expv;
    } vec_t;

    typedef struct {
        int y;
        int t;
    } sb_t;

    vec_t vt [0:9];
    int   nvt = 0;
    int   e12 [12];
    sb_t  sbq [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vout_cnt = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        sb_t e;
        if (!rst && vout) begin
            vout_cnt++;
            if (sbq.size() == 0)
                check("spurious_vout", int'(vout), 0);
            else begin
                e = sbq.pop_front();
                check("y", int'(y), e.y);
                check("latency", cyc - e.t, 11);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_coefs(input int k, input logic [15:0] aval);
        for (int i = 0; i <= 10; i++) a[i] = '0;
        a[k] = aval;
    endtask

    task automatic load_start(input logic vcd, input logic [15:0] fc);
        voiced = vcd; freq_count = fc;
        load = 1'b1; step(1); load = 1'b0;
        start_dec = 1'b1; step(1); start_dec = 1'b0;
    endtask

    task automatic strobe(input int expv);
        sb_t e;
        e.y = expv;
        e.t = cyc + 1;
        sbq.push_back(e);
        v = 1'b1; step(1); v = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 40) begin step(1); k++; end
        if (sbq.size() != 0) begin
            check(name, sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic add_vec(input int k, input int aval, input logic vcd, input int fc, input int n);
        vt[nvt].k    = 4'(k);
        vt[nvt].aval = 16'(aval);
        vt[nvt].vcd  = vcd;
        vt[nvt].fc   = 16'(fc);
        vt[nvt].n    = 4'(n);
        for (int j = 0; j < 12; j++) vt[nvt].expv[j] = 16'(e12[j]);
        nvt++;
    endtask

    initial begin
        int c0;
        rst = 1'b1; voiced = 1'b0; freq_count = '0;
        load = 1'b0; start_dec = 1'b0; stop_dec = 1'b0; v = 1'b0;
        for (int i = 0; i <= 10; i++) a[i] = '0;

        e12 = '{4096, 0, 0, 0, 4096, 0, 0, 0, 0, 0, 0, 0};            add_vec(1, 0, 1'b1, 4, 8);
        e12 = '{4096, 2048, 1024, 512, 4352, 2176, 0, 0, 0, 0, 0, 0}; add_vec(1, -4096, 1'b1, 4, 6);
        e12 = '{4096, 8192, 16384, 32767, 32767, 0, 0, 0, 0, 0, 0, 0}; add_vec(1, -16384, 1'b1, 100, 5);
        e12 = '{-2660, 2766, -2713, 0, 0, 0, 0, 0, 0, 0, 0, 0};       add_vec(1, 0, 1'b0, 4, 3);
        e12 = '{4096, -8192, 16384, -28672, 32767, -32768, 0, 0, 0, 0, 0, 0}; add_vec(1, 16384, 1'b1, 3, 6);
        e12 = '{4096, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4096, 0};            add_vec(10, -8192, 1'b1, 100, 11);
        e12 = '{4096, 0, 2048, 0, 1024, 0, 0, 0, 0, 0, 0, 0};         add_vec(2, -4096, 1'b1, 100, 5);
        e12 = '{4096, 4096, 4096, 0, 0, 0, 0, 0, 0, 0, 0, 0};         add_vec(1, 0, 1'b1, 1, 3);
        e12 = '{-2660, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};              add_vec(1, 0, 1'b1, 0, 1);

        step(3);
        check("rst_y", int'(y), 0);
        check("rst_vout", int'(vout), 0);
        check("rst_running", int'(running), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        step(2);

        for (int i = 0; i < nvt; i++) begin
            set_coefs(int'(vt[i].k), vt[i].aval);
            load_start(vt[i].vcd, vt[i].fc);
            check("running", int'(running), 1);
            for (int j = 0; j < int'(vt[i].n); j++) begin
                strobe(int'($signed(vt[i].expv[j])));
                step(11);
            end
            drain("vec_drain");
        end

        // v 5 clocks after an accepted v is dropped and flagged
        set_coefs(1, 16'd0);
        load_start(1'b1, 16'd4);
        check("ovr_clear", int'(overrun), 0);
        c0 = vout_cnt;
        strobe(4096);
        step(4);
        v = 1'b1; step(1); v = 1'b0;
        check("ovr_set", int'(overrun), 1);
        step(20);
        drain("ovr_drain");
        check("ovr_vouts", vout_cnt - c0, 1);
        check("ovr_sticky", int'(overrun), 1);

        // load mid-MAC must not affect the sample in flight
        set_coefs(1, -16'sd4096);
        load_start(1'b1, 16'd100);
        check("ovr_restart", int'(overrun), 0);
        strobe(4096);
        step(11);
        set_coefs(1, 16'd0);
        strobe(2048);
        step(3);
        load = 1'b1; step(1); load = 1'b0;
        step(7);
        strobe(0);
        step(11);
        drain("load_drain");

        // async reset during MAC cycle 5
        load_start(1'b1, 16'd100);
        strobe(4096);
        step(11);
        drain("pre_rst_drain");
        v = 1'b1; step(1); v = 1'b0;
        step(4);
        rst = 1'b1;
        #1;
        check("amid_rst_y", int'(y), 0);
        check("amid_rst_vout", int'(vout), 0);
        check("amid_rst_running", int'(running), 0);
        step(2);
        rst = 1'b0;
        step(15);
        check("amid_rst_no_vout", int'(vout), 0);

        // stop_dec and v together: stop wins
        set_coefs(1, 16'd0);
        load_start(1'b1, 16'd4);
        c0 = vout_cnt;
        v = 1'b1; stop_dec = 1'b1; step(1); v = 1'b0; stop_dec = 1'b0;
        check("stop_v_running", int'(running), 0);
        step(15);
        check("stop_v_vouts", vout_cnt - c0, 0);

        // v in IDLE is ignored silently
        v = 1'b1; step(1); v = 1'b0;
        step(14);
        check("idle_v_vouts", vout_cnt - c0, 0);
        check("idle_v_overrun", int'(overrun), 0);

        // stop_dec mid-MAC aborts the sample
        load_start(1'b1, 16'd4);
        v = 1'b1; step(1); v = 1'b0;
        step(3);
        stop_dec = 1'b1; step(1); stop_dec = 1'b0;
        step(15);
        check("stop_mac_vouts", vout_cnt - c0, 0);
        check("stop_mac_running", int'(running), 0);

        // history cleared by stop: a fresh start reproduces the first impulse
        set_coefs(1, -16'sd4096);
        load_start(1'b1, 16'd100);
        strobe(4096);
        step(11);
        strobe(2048);
        step(11);
        drain("restart_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
